// File: rtl/mem_access_ctrl_if.sv
// CPU-side and memory-side bus bundle for mem_access_ctrl.
// slave = controller view, master = CPU plus data-memory view.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [3:0]        cpu_len;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_wready;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_busy;
   logic              cpu_done;
   logic              err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_en;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_len, cpu_wdata, mem_rdata,
      output cpu_wready, cpu_rvalid, cpu_rdata, cpu_busy, cpu_done, err,
             mem_addr, mem_wdata, mem_read, mem_en
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_len, cpu_wdata, mem_rdata,
      input  cpu_wready, cpu_rvalid, cpu_rdata, cpu_busy, cpu_done, err,
             mem_addr, mem_wdata, mem_read, mem_en
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Burst read/write controller between a CPU strobe interface and a single-port data memory.
// Define WRITE_VERIFY_EN to follow every write beat with a read-back verify cycle.
module mem_access_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_ctrl_if.slave  bus
);

`ifdef WRITE_VERIFY_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_VFY = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;
`endif

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_read_q, mem_read_d;
   logic              wready_q, wready_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef WRITE_VERIFY_EN
   logic              err_q, err_d;
`endif

   // All outputs except mem_wdata are registered: the cycle's issue is decided one edge earlier.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_addr_d = mem_addr_q;
      wdata_d    = wdata_q;
      mem_en_d   = 1'b0;
      mem_read_d = 1'b1;
      wready_d   = 1'b0;
      rvalid_d   = 1'b0;
      rdata_d    = rdata_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
`ifdef WRITE_VERIFY_EN
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req) begin
               cnt_d      = bus.cpu_len;
               mem_addr_d = bus.cpu_addr;
               mem_en_d   = 1'b1;
               busy_d     = 1'b1;
`ifdef WRITE_VERIFY_EN
               err_d      = 1'b0;
`endif
               if (bus.cpu_we) begin
                  state_d    = S_WR;
                  mem_read_d = 1'b0;
                  wready_d   = 1'b1;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            rvalid_d = 1'b1;
            rdata_d  = bus.mem_rdata;
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d      = cnt_q - 4'd1;
               mem_addr_d = mem_addr_q + ADDR_W'(1);
               mem_en_d   = 1'b1;
            end
         end
         S_WR: begin
            wdata_d = bus.cpu_wdata;
`ifdef WRITE_VERIFY_EN
            state_d  = S_VFY;
            mem_en_d = 1'b1;
`else
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d      = cnt_q - 4'd1;
               mem_addr_d = mem_addr_q + ADDR_W'(1);
               mem_en_d   = 1'b1;
               mem_read_d = 1'b0;
               wready_d   = 1'b1;
            end
`endif
         end
`ifdef WRITE_VERIFY_EN
         S_VFY: begin
            if (bus.mem_rdata != wdata_q) begin
               err_d = 1'b1;
            end
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d    = S_WR;
               cnt_d      = cnt_q - 4'd1;
               mem_addr_d = mem_addr_q + ADDR_W'(1);
               mem_en_d   = 1'b1;
               mem_read_d = 1'b0;
               wready_d   = 1'b1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         mem_addr_q <= '0;
         wdata_q    <= '0;
         mem_en_q   <= 1'b0;
         mem_read_q <= 1'b1;
         wready_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef WRITE_VERIFY_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         wdata_q    <= wdata_d;
         mem_en_q   <= mem_en_d;
         mem_read_q <= mem_read_d;
         wready_q   <= wready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef WRITE_VERIFY_EN
         err_q      <= err_d;
`endif
      end
   end

   // Write data passes straight through during a beat, then holds the last beat's value.
   assign bus.mem_wdata  = (state_q == S_WR) ? bus.cpu_wdata : wdata_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_read   = mem_read_q;
   assign bus.cpu_wready = wready_q;
   assign bus.cpu_rvalid = rvalid_q;
   assign bus.cpu_rdata  = rdata_q;
   assign bus.cpu_busy   = busy_q;
   assign bus.cpu_done   = done_q;
`ifdef WRITE_VERIFY_EN
   assign bus.err        = err_q;
`else
   assign bus.err        = 1'b0;
`endif

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cpu_req  input  1  start strobe; sampled only in IDLE.
REQ-006 SHALL have port cpu_we  input  1  1 = write burst, 0 = read burst; captured with cpu_req.
REQ-007 SHALL have port cpu_addr  input  ADDR_W  start address; captured with cpu_req.
REQ-008 SHALL have port cpu_len  input  4  beat count minus one (0 = 1 beat, 15 = 16 beats); captured with cpu_req.
REQ-009 SHALL have port cpu_wdata  input  DATA_W  write data, consumed in any cycle where cpu_wready=1.
REQ-010 SHALL have port cpu_wready  output  1  current write beat consumes cpu_wdata this cycle.
REQ-011 SHALL have port cpu_rvalid  output  1  cpu_rdata holds a valid read beat.
REQ-012 SHALL have port cpu_rdata  output  DATA_W  registered read data.
REQ-013 SHALL have port cpu_busy  output  1  transfer in progress.
REQ-014 SHALL have port cpu_done  output  1  one-cycle pulse at transfer completion.
REQ-015 SHALL have port err  output  1  sticky write-verify mismatch flag.
REQ-016 SHALL have port mem_addr  output  ADDR_W  data-memory address.
REQ-017 SHALL have port mem_wdata  output  DATA_W  data-memory write data.
REQ-018 SHALL have port mem_read  output  1  1 = read, 0 = write; matches the data-memory read polarity.
REQ-019 SHALL have port mem_en  output  1  access strobe, 1 in every issue cycle.
REQ-020 SHALL have port mem_rdata  input  DATA_W  combinational data-memory read data.

Function
REQ-021 SHALL implement FSM states IDLE, RD, WR and VFY; VFY exists only under the macro in REQ-037.
REQ-022 In IDLE with cpu_req=1, SHALL capture cpu_addr, cpu_we and cpu_len, and enter WR if cpu_we=1, otherwise RD; cpu_busy=1 from the next cycle.
REQ-023 SHALL ignore cpu_req whenever the FSM is not in IDLE.
REQ-024 In RD, each cycle SHALL drive mem_en=1, mem_read=1 and mem_addr=current address, then increment the address; throughput is one beat per cycle.
REQ-025 SHALL register mem_rdata into cpu_rdata and assert cpu_rvalid=1 in the cycle after each RD issue (read latency 1).
REQ-026 In WR, SHALL drive mem_en=1, mem_read=0, mem_wdata=cpu_wdata (combinational) and cpu_wready=1 for one cycle per beat.
REQ-027 SHALL wrap the address modulo 2^ADDR_W (for example, 8'hFF+1 = 8'h00) with no error.
REQ-028 After the final beat issue, SHALL return to IDLE; cpu_done SHALL pulse for one cycle, coincident with the last cpu_rvalid for reads and in the first IDLE cycle for writes; cpu_busy SHALL drop in that same cycle.
REQ-029 Outside WR beats, SHALL hold mem_read=1 so that the memory is never written unintentionally.
REQ-030 Outside issue cycles, SHALL drive mem_en=0, with mem_addr and mem_wdata holding their last values.
REQ-031 SHALL start a request presented in the cycle cpu_done is high only if the FSM is in IDLE; back-to-back transfers SHALL therefore be allowed with no gap.

Reset
REQ-032 While rst=1 at a clock edge, SHALL set FSM=IDLE, cpu_busy=0, cpu_done=0, cpu_rvalid=0, cpu_wready=0, cpu_rdata=0, err=0, mem_en=0, mem_read=1, mem_addr=0 and mem_wdata=0.
REQ-033 Reset mid-transfer SHALL abort the transfer with no further mem_en, no cpu_done and no pending cpu_rvalid.

Configuration
REQ-034 Macro WRITE_VERIFY_EN SHALL select write-verify behaviour.
REQ-035 When WRITE_VERIFY_EN is defined, each WR beat SHALL be followed by one VFY cycle with mem_en=1, mem_read=1 and the same address; in VFY, cpu_wready=0.
REQ-036 When WRITE_VERIFY_EN is defined and mem_rdata differs from the written data in VFY, err SHALL set and remain 1 until rst or the next accepted cpu_req; a write beat then costs 2 cycles.
REQ-037 When WRITE_VERIFY_EN is undefined, the VFY state SHALL be absent, err SHALL be tied 0, and a write beat costs 1 cycle.

Verification
REQ-038 Bench SHALL cover: read, cpu_addr=8'h05, cpu_len=3, memory word n = n -> cpu_rvalid for 4 consecutive cycles with cpu_rdata 5,6,7,8; cpu_done coincident with 8.
REQ-039 Bench SHALL cover: write, cpu_addr=8'h10, cpu_len=1, wdata 16'hAAAA then 16'h5555 -> memory[0x10]=AAAA and memory[0x11]=5555; err=0; then read back returns the same values.
REQ-040 Bench SHALL cover: read, cpu_addr=8'hFE, cpu_len=3 -> mem_addr sequence FE,FF,00,01.
REQ-041 Bench SHALL cover: cpu_req pulsed during a busy read -> request ignored; exactly cpu_len+1 beats are issued.
REQ-042 Bench SHALL cover: rst asserted on beat 2 of a 4-beat write -> next cycle mem_en=0, mem_read=1, cpu_busy=0; only 2 words written.
REQ-043 Bench SHALL cover, under WRITE_VERIFY_EN: memory model corrupts address 0x20 -> write to 0x20 sets err=1, err holds until the next cpu_req, and a 4-beat write takes 8 cycles.
